// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder walks WIDTH-bit operands LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;
  logic             busy_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign accept   = (state == ST_IDLE) && in_start;
  assign last_bit = (state == ST_RUN) && (cnt_q == CW'(WIDTH - 1));

  // Subtraction is A + ~B + 1, so the B register and carry are preconditioned at capture.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = in_sub ? ~in_b : in_b;
  assign carry_load = in_sub ? 1'b1 : in_ci;
`else
  assign b_load     = in_b;
  assign carry_load = in_ci;
`endif

  serial_adder_fa u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are computed from the next state and registered below.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      ST_RUN:  busy_nxt = 1'b1;
      ST_DONE: begin
        busy_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_busy <= 1'b0;
      out_done <= 1'b0;
    end else begin
      out_busy <= busy_nxt;
      out_done <= done_nxt;
    end
  end

  // Datapath: capture, shift one bit per RUN cycle, publish only on the final bit.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_s   <= '0;
      out_co  <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= b_load;
      carry_q <= carry_load;
      cnt_q   <= '0;
    end else if (state == ST_RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= {fa_s, res_q[WIDTH-1:1]};
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CW'(1);
      if (last_bit) begin
        out_s  <= {fa_s, res_q[WIDTH-1:1]};
        out_co <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: transaction-level model plus directed cases.
// Subtract cases are included when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned W4 = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;

  logic          start4;
  logic [W4-1:0] a4;
  logic [W4-1:0] b4;
  logic          ci4;
  logic          busy4;
  logic          done4;
  logic [W4-1:0] s4;
  logic          co4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .in_start (start),
    .in_a     (a),
    .in_b     (b),
    .in_ci    (ci),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub   (sub),
`endif
    .out_busy (busy),
    .out_done (done),
    .out_s    (s),
    .out_co   (co)
  );

  serial_adder_ctrl #(.WIDTH(W4)) dut4 (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .in_start (start4),
    .in_a     (a4),
    .in_b     (b4),
    .in_ci    (ci4),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub   (1'b0),
`endif
    .out_busy (busy4),
    .out_done (done4),
    .out_s    (s4),
    .out_co   (co4)
  );

  // Transaction model: an accepted start yields its sum WIDTH+1 edges later.
  int           m_rem;
  logic [W:0]   m_pend;
  logic         m_busy;
  logic         m_done;
  logic [W-1:0] m_s;
  logic         m_co;
  logic [W-1:0] m_nb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_pend = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_s    = '0;
      m_co   = 1'b0;
    end else if (m_rem == 0) begin
      m_done = 1'b0;
      if (start) begin
        m_nb   = ~b;
        m_pend = sub ? ({1'b0, a} + {1'b0, m_nb} + (W+1)'(1))
                     : ({1'b0, a} + {1'b0, b} + (W+1)'(ci));
        m_rem  = int'(W) + 1;
        m_busy = 1'b1;
      end
    end else begin
      m_rem  = m_rem - 1;
      m_done = (m_rem == 1);
      if (m_rem == 1) {m_co, m_s} = m_pend;
      if (m_rem == 0) m_busy = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("sum",  32'(s),    32'(m_s));
      check("co",   32'(co),   32'(m_co));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                        input logic tsub, input logic [W-1:0] es, input logic eco);
    int lat;
    bit got;
    a = ta; b = tb; ci = tci; sub = tsub; start = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      step();
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      lat++;
      if (done) got = 1'b1;
    end
    check("latency", 32'(lat), 32'(W + 1));
    check("op_sum",  32'(s),   32'(es));
    check("op_co",   32'(co),  32'(eco));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb, nb;
    logic         rci, rsub;
    logic [W:0]   sum;
    int           pulses, lat4;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(s),    32'd0);
    check("rst_co",   32'(co),   32'd0);
    rst_n = 1'b1;
    step();

    // Directed arithmetic with hand-computed results
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
`endif

    // Start held high: back-to-back operations every WIDTH+2 cycles, operands churning
    pulses = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      step();
      if (done) pulses++;
    end
    start = 1'b0;
    check("busy_pulses", 32'(pulses), 32'd3);
    repeat (2) step();

    // Abort mid-RUN with reset
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    a = 8'h33; b = 8'h44; ci = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(s),    32'd0);
    check("abort_co",   32'(co),   32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'd0);
      if (i == 2) rst_n = 1'b1;
    end
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);

    // Randomized operations against plain arithmetic
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      nb  = ~rb;
      sum = rsub ? ({1'b0, ra} + {1'b0, nb} + (W+1)'(1))
                 : ({1'b0, ra} + {1'b0, rb} + (W+1)'(rci));
      run_op(ra, rb, rci, rsub, sum[W-1:0], sum[W]);
      repeat ($urandom_range(0, 2)) step();
    end
    sub = 1'b0;

    // Narrow instance: WIDTH=4
    a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1; start4 = 1'b1;
    lat4 = 0;
    while (lat4 < 20 && !done4) begin
      step();
      start4 = 1'b0;
      a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
      lat4++;
    end
    check("w4_latency", 32'(lat4), 32'd5);
    check("w4_sum",     32'(s4),   32'hF);
    check("w4_co",      32'(co4),  32'd1);
    step();
    check("w4_idle",    32'(busy4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
